// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch control and BCD mm:ss.cc timekeeping.
// Turns two debounced active-low keys into single-cycle press events. A
// four-state FSM uses those events to run, pause, lap-freeze and clear the
// count.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key_start  debounced start/stop key, active low (idle 1)
//   key_lap    debounced lap/reset key, active low (idle 1)
//   disp_cs    displayed centiseconds, BCD {tens, units}
//   disp_sec   displayed seconds, BCD
//   disp_min   displayed minutes, BCD
//   running    high in RUN and LAP
//   lap_hold   high in LAP (display frozen on the snapshot)
//   wrap       one-cycle pulse after the 59:59.99 -> 00:00.00 rollover
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_lap,
  output logic [7:0] disp_cs,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_min,
  output logic       running,
  output logic       lap_hold,
  output logic       wrap
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  // Per-digit maxima, packed {min_t, min_u, sec_t, sec_u, cs_t, cs_u}.
  localparam logic [23:0] DMAX = 24'h595999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          ks_q, kl_q;
  logic          start_p, lap_p;
  logic [PW-1:0] presc;
  logic [23:0]   cnt, cnt_nxt, snap, disp;
  logic          counting, tick, all_max, carry;
  logic          snap_en, clr;

  // Falling edge of an active-low key is a press; release gives nothing.
  assign start_p  = ks_q & ~key_start;
  assign lap_p    = kl_q & ~key_lap;

  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (presc == PMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start_p is tested first everywhere, so a simultaneous lap_p is dropped.
  always_comb begin
    state_nxt = state;
    snap_en   = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_p) state_nxt = RUN;
      end
      RUN: begin
        if (start_p) begin
          state_nxt = PAUSE;
        end else if (lap_p) begin
          state_nxt = LAP;
          snap_en   = 1'b1;
        end
      end
      LAP: begin
        if (start_p)    state_nxt = PAUSE;
        else if (lap_p) state_nxt = RUN;
      end
      PAUSE: begin
        if (start_p) begin
          state_nxt = RUN;
        end else if (lap_p) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ripple increment: a digit at its maximum rolls to 0 and passes the carry
  // on; a carry surviving all six digits marks the full rollover.
  always_comb begin
    cnt_nxt = cnt;
    carry   = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (cnt[i*4 +: 4] == DMAX[i*4 +: 4]) begin
          cnt_nxt[i*4 +: 4] = 4'd0;
        end else begin
          cnt_nxt[i*4 +: 4] = cnt[i*4 +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    all_max = carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_q  <= 1'b1;
      kl_q  <= 1'b1;
      presc <= '0;
      cnt   <= '0;
      snap  <= '0;
      wrap  <= 1'b0;
    end else begin
      ks_q <= key_start;
      kl_q <= key_lap;
      wrap <= tick & all_max;
      if (clr) begin
        presc <= '0;
        cnt   <= '0;
      end else begin
        // PAUSE keeps the partial centisecond in presc.
        if (counting)           presc <= tick ? '0 : presc + PW'(1);
        else if (state == IDLE) presc <= '0;
        if (tick)               cnt   <= cnt_nxt;
      end
      // Snapshot takes the pre-increment count even when tick fires now.
      if (snap_en) snap <= cnt;
    end
  end

  assign running  = counting;
  assign lap_hold = (state == LAP);
  assign disp     = lap_hold ? snap : cnt;
  assign disp_cs  = disp[7:0];
  assign disp_sec = disp[15:8];
  assign disp_min = disp[23:16];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV = 4. A reference model keeps the
// time as a plain centisecond total and the mode as an integer; displayed
// BCD is derived by division. Directed scenarios pin the model with literal
// expectations; a random key phase follows.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int WRAP_CS = 360000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b1;
  logic       key_lap = 1'b1;
  logic [7:0] disp_cs, disp_sec, disp_min;
  logic       running, lap_hold, wrap;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_lap(key_lap),
    .disp_cs(disp_cs), .disp_sec(disp_sec), .disp_min(disp_min),
    .running(running), .lap_hold(lap_hold), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int total;
    int pre;
    int snap;
    bit wrp;
    bit ks;
    bit kl;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = M_IDLE; r.total = 0; r.pre = 0; r.snap = 0;
    r.wrp = 1'b0; r.ks = 1'b1; r.kl = 1'b1;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic ks, input logic kl,
                                input bit pl, input int plv);
    mdl_t n;
    bit sp, lp, act, tk;
    int t0;
    n  = s;
    t0 = pl ? plv : s.total;
    n.total = t0;
    sp  = s.ks && !ks;
    lp  = s.kl && !kl;
    act = (s.mode == M_RUN) || (s.mode == M_LAP);
    tk  = act && (s.pre == TD - 1);
    n.wrp = tk && (t0 == WRAP_CS - 1);
    if (act)                 n.pre = tk ? 0 : s.pre + 1;
    else if (s.mode == M_IDLE) n.pre = 0;
    if (tk) n.total = (t0 + 1) % WRAP_CS;
    case (s.mode)
      M_IDLE:  if (sp) n.mode = M_RUN;
      M_RUN: begin
        if (sp) n.mode = M_PAUSE;
        else if (lp) begin n.mode = M_LAP; n.snap = t0; end
      end
      M_LAP: begin
        if (sp) n.mode = M_PAUSE;
        else if (lp) n.mode = M_RUN;
      end
      default: begin
        if (sp) n.mode = M_RUN;
        else if (lp) begin n.mode = M_IDLE; n.total = 0; n.pre = 0; end
      end
    endcase
    n.ks = ks;
    n.kl = kl;
    return n;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [23:0] show(input int t);
    return {bcd(t / 6000), bcd((t / 100) % 60), bcd(t % 100)};
  endfunction

  mdl_t m;
  bit   pl_req = 1'b0;
  int   pl_val = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mdl_reset();
    else     m <= step(m, key_start, key_lap, pl_req, pl_val);
  end

  int   ntot = 0;
  int   nbad = 0;
  bit   chk_en = 1'b0;
  logic [23:0] c_exp, c_act;
  logic [2:0]  f_exp, f_act;

  task automatic lit(input string name, input logic [23:0] act, input logic [23:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit_disp(input string name, input logic [23:0] exp);
    lit(name, {disp_min, disp_sec, disp_cs}, exp);
  endtask

  task automatic lit_flags(input string name, input logic [2:0] exp);
    lit(name, {21'd0, running, lap_hold, wrap}, {21'd0, exp});
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
          c_exp = show((m.mode == M_LAP) ? m.snap : m.total);
          c_act = {disp_min, disp_sec, disp_cs};
          ntot++;
          if (c_act !== c_exp) begin
            nbad++;
            $display("FAIL model_disp: got %h want %h at %0t", c_act, c_exp, $time);
          end
          f_exp = {(m.mode == M_RUN) || (m.mode == M_LAP), m.mode == M_LAP, m.wrp};
          f_act = {running, lap_hold, wrap};
          ntot++;
          if (f_act !== f_exp) begin
            nbad++;
            $display("FAIL model_flags: got %b want %b at %0t", f_act, f_exp, $time);
          end
        end
      end
    join_none

    // Reset asserted from time 0, before any clock edge.
    #2;
    lit_disp("reset_disp", 24'h000000);
    lit_flags("reset_flags", 3'b000);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Start: key held low 10 cycles, RUN entry edge N.
    @(negedge clk);
    key_start = 1'b0;
    cyc(1);  lit_flags("start_run", 3'b100); lit_disp("start_n0", 24'h000000);
    cyc(3);  lit_disp("start_n3", 24'h000000);
    cyc(1);  lit_disp("start_n4", 24'h000001);
    cyc(5);  key_start = 1'b1;
    cyc(391); lit_disp("start_n400", 24'h000100); lit_flags("start_held", 3'b100);

    // Lap at 00:01.23, display frozen, second lap 40 cycles later.
    cyc(92); lit_disp("pre_lap", 24'h000123);
    key_lap = 1'b0;
    cyc(1);  lit_flags("lap_enter", 3'b110); lit_disp("lap_frz0", 24'h000123);
    cyc(4);  key_lap = 1'b1;
    cyc(35); lit_disp("lap_frz39", 24'h000123);
    key_lap = 1'b0;
    cyc(1);  lit_disp("lap_exit", 24'h000133); lit_flags("lap_exit_f", 3'b100);
    key_lap = 1'b1;

    // Pause 2 cycles into a centisecond, resume: tick 2 cycles later.
    key_start = 1'b0;
    cyc(1);  lit_flags("pause", 3'b000); lit_disp("pause_d", 24'h000133);
    cyc(2);  key_start = 1'b1;
    cyc(8);  lit_disp("pause_frz", 24'h000133);
    key_start = 1'b0;
    cyc(1);  lit_flags("resume", 3'b100); lit_disp("resume_r0", 24'h000133);
    cyc(1);  lit_disp("resume_r1", 24'h000133);
    cyc(1);  lit_disp("resume_r2", 24'h000134);
    key_start = 1'b1;
    cyc(1);  key_start = 1'b0;
    cyc(1);  lit_flags("pause2", 3'b000);
    key_start = 1'b1;
    cyc(2);  key_lap = 1'b0;
    cyc(1);  lit_disp("clear", 24'h000000); lit_flags("clear_f", 3'b000);
    key_lap = 1'b1;
    cyc(2);

    // Simultaneous start and lap in RUN: PAUSE only.
    key_start = 1'b0;
    cyc(1);  key_start = 1'b1;
    cyc(10);
    key_start = 1'b0; key_lap = 1'b0;
    cyc(1);  lit_flags("both_pause", 3'b000);
    key_start = 1'b1; key_lap = 1'b1;
    cyc(2);

    // Preload 59:59.98 while paused, then run through the rollover.
    chk_en = 1'b0;
    #2;
    force dut.cnt = 24'h595998;
    pl_val = WRAP_CS - 2;
    pl_req = 1'b1;
    #1;
    release dut.cnt;
    @(posedge clk);
    #1 pl_req = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    lit_disp("preload", 24'h595998);
    key_start = 1'b0;
    cyc(1);  key_start = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (m.wrp) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      if (!seen) begin
        nbad++; ntot++;
        $display("FAIL wrap_timeout: got none want wrap within 40 cycles");
      end
    end
    lit_disp("wrap_d", 24'h000000);
    lit_flags("wrap_f", 3'b101);
    cyc(1);  lit_flags("wrap_end", 3'b100);

    // Random key activity.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) key_start = ~key_start;
      if ($urandom_range(0, 15) == 0) key_lap = ~key_lap;
      @(negedge clk);
    end
    key_start = 1'b1; key_lap = 1'b1;
    cyc(2);

    // Async reset mid-count at 00:03.47.
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cyc(1); key_start = 1'b0;
    cyc(1); key_start = 1'b1;
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (m.total == 347) begin hit = 1'b1; break; end
      end
      if (!hit) begin
        nbad++; ntot++;
        $display("FAIL reach_347: got %0d want 347", m.total);
      end
    end
    lit_disp("pre_rst", 24'h000347);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    lit_disp("async_rst_d", 24'h000000);
    lit_flags("async_rst_f", 3'b000);
    key_start = 1'b0;
    @(negedge clk); rst = 1'b0;
    cyc(1); lit_flags("held_key_run", 3'b100);
    cyc(6); lit_flags("held_key_once", 3'b100);
    key_start = 1'b1;
    cyc(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch control and timekeeping stage that sits directly downstream of the key debouncers. It turns two debounced, active-low push-button levels (start/stop, lap/reset) into single-cycle press events. A four-state FSM uses those events to run, pause, lap-freeze and clear a BCD mm:ss.cc time counter. The BCD digits it outputs feed the seven-segment display driver.

## Interface
- `TICK_DIV`, default 500_000: clk cycles per centisecond. The default gives 10 ms at 50 MHz (20 ns clk). The minimum is 2.
- `clk`  in  1: system clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `key_start`  in  1: debounced start/stop key. Active-low; idle level is 1.
- `key_lap`  in  1: debounced lap/reset key. Active-low; idle level is 1.
- `disp_cs`  out  8: displayed centiseconds as BCD {tens, units}, 0x00–0x99.
- `disp_sec`  out  8: displayed seconds as BCD, 0x00–0x59.
- `disp_min`  out  8: displayed minutes as BCD, 0x00–0x59.
- `running`  out  1: high in RUN and LAP.
- `lap_hold`  out  1: high in LAP, meaning the display is frozen.
- `wrap`  out  1: one-cycle pulse when the count rolls from 59:59.99 to 00:00.00.

## Operation
- Press detection
  - Registers `ks_q` and `kl_q` hold the previous key levels. Both reset to 1.
  - `start_p = ks_q & ~key_start`. `lap_p = kl_q & ~key_lap`.
  - Each press produces exactly one pulse, however long the key is held. Release produces no event.
- FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3. Reset state is IDLE.
  - IDLE: `start_p` → RUN. `lap_p` is ignored.
  - RUN: `start_p` → PAUSE. `lap_p` → LAP, and the current count is snapshotted.
  - LAP: `start_p` → PAUSE, with the display live again. `lap_p` → RUN, with the display live again.
  - PAUSE: `start_p` → RUN. `lap_p` → IDLE; the count and the prescaler are cleared.
  - If `start_p` and `lap_p` occur in the same cycle, `start_p` wins and `lap_p` is dropped.
- Prescaler
  - Counts 0..`TICK_DIV`-1 in RUN and in LAP.
  - `tick` is asserted when the prescaler equals `TICK_DIV`-1; the prescaler then wraps to 0.
  - In PAUSE the prescaler holds its value, so a resumed run keeps the partial centisecond.
  - In IDLE the prescaler is held at 0.
- Time counter: six BCD digits, each a 4-bit register.
  - Digit ranges: cs units 0–9, cs tens 0–9, sec units 0–9, sec tens 0–5, min units 0–9, min tens 0–5.
  - On `tick`, cs units increments. Each digit carries into the next when it is at its maximum.
  - All digits at maximum plus `tick` → all digits 0, and `wrap`=1 for that cycle. Counting continues.
  - No digit ever takes a non-BCD value.
- Snapshot
  - On the RUN→LAP edge, the snapshot register captures the count value present before that edge's increment. This applies even if `tick` fires in the same cycle.
  - Display outputs = snapshot when in LAP; otherwise they equal the live count.
- Reset
  - On `rst`, state=IDLE, and the count, snapshot and prescaler are all 0. `ks_q`/`kl_q`=1.
  - All outputs read 0: `disp_*`=0x00, `running`=0, `lap_hold`=0, `wrap`=0.
  - This takes effect immediately, without waiting for `clk`, including mid-run.
- Key held low across reset release: produces one press on the first `clk` edge after release.

## Timing
- Let N be the first rising edge at which a key is sampled low. The state change, `running` and `lap_hold` are valid after edge N, so press-to-state latency is 1 cycle.
- RUN entered from IDLE at edge N → `disp_cs`=0x01 after edge N+`TICK_DIV`.
- One centisecond is exactly `TICK_DIV` cycles of RUN or LAP time.
- `wrap` is registered. It is high for exactly the cycle following the tick that caused the rollover.
- All outputs are registered; there is no combinational path from a key input to any output.
- `rst` deassertion is assumed synchronised upstream.

## Test plan
All scenarios use `TICK_DIV`=4.
- **Reset:** assert `rst` mid-count (count 00:03.47) between clock edges → all outputs go to 0 before the next edge; state is IDLE.
- **Start:** drive `key_start` low for 10 cycles in IDLE → `running`=1 after 1 edge. `disp_cs`=0x01 exactly 4 cycles after RUN entry. After 400 RUN cycles, `disp_sec`=0x01 and `disp_cs`=0x00. Holding the key produces no second toggle.
- **Lap:** press lap at 00:01.23 → `lap_hold`=1 and the display stays 0x00/0x01/0x23 while the internal count advances. Press lap again 40 cycles later → display shows 00:01.33.
- **Pause and clear:** press start in RUN → the count freezes. Press lap → IDLE with all digits 0x00. Press start and lap in the same cycle while in RUN → PAUSE only.
- **Wrap:** preload or run to 59:59.99, then one tick → 00:00.00 with `wrap` high for one cycle, and `running` stays 1.
- **Partial centisecond:** pause 2 cycles into a centisecond and then resume → the next tick arrives 2 cycles after resume, not 4.
